// File: rtl/blink_rate_decoder.sv
// blink_rate_decoder
//   Receive side of the LED blink scheme. Measures the half-period of the
//   square wave on blink_in and decodes it back to the 2-bit rate select
//   that produced it: 2'b00 = HALF_MID, 2'b01 = HALF_SLOW, 2'b10 = HALF_FAST.
//   A code is reported as locked only after two consecutive intervals agree.
//   Long silence on the input is flagged as a stall.
//
//   Optional build macro: RATE_DEBUG_EN adds the last_interval output, which
//   carries the most recent judged interval length.
//
//   Timing from a blink_in transition to rate_strobe / rate_err is
//   SYNC_STAGES + 2 clocks:
//     - SYNC_STAGES clocks in the synchronizer,
//     - one clock in the registered edge detect,
//     - one clock in the registered outputs.
module blink_rate_decoder #(
  parameter int CNT_W       = 28,
  parameter int HALF_MID    = 50_000_000,
  parameter int HALF_SLOW   = 90_000_000,
  parameter int HALF_FAST   = 25_000_000,
  parameter int TOL         = 1_000_000,
  parameter int TIMEOUT     = 120_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             blink_in,
  output logic [1:0]       rate_code,
  output logic             rate_valid,
  output logic             rate_strobe,
  output logic             rate_err,
  output logic             stalled
`ifdef RATE_DEBUG_EN
  ,output logic [CNT_W-1:0] last_interval
`endif
);

  // Interval arithmetic is one bit wider than the counter, so that
  // TIMEOUT+1 and the window bounds never wrap.
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   ival_t;

  localparam cnt_t  TIMEOUT_C = cnt_t'(TIMEOUT);

  localparam ival_t FAST_LO = ival_t'((HALF_FAST > TOL) ? HALF_FAST - TOL : 0);
  localparam ival_t FAST_HI = ival_t'(HALF_FAST + TOL);
  localparam ival_t MID_LO  = ival_t'((HALF_MID  > TOL) ? HALF_MID  - TOL : 0);
  localparam ival_t MID_HI  = ival_t'(HALF_MID  + TOL);
  localparam ival_t SLOW_LO = ival_t'((HALF_SLOW > TOL) ? HALF_SLOW - TOL : 0);
  localparam ival_t SLOW_HI = ival_t'(HALF_SLOW + TOL);

  localparam logic [1:0] CODE_MID  = 2'b00;
  localparam logic [1:0] CODE_SLOW = 2'b01;
  localparam logic [1:0] CODE_FAST = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // waiting for an arming edge
    ARMED  = 2'd1,  // reference edge seen, next interval is judged
    CAND   = 2'd2,  // one matching interval seen, held in cand
    LOCKED = 2'd3   // two consecutive intervals agreed
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer and registered edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  // Shift the asynchronous input through the synchronizer chain and compare
  // the synced value against its previous value (either polarity).
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], blink_in};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Synchronizer, previous-value and edge flops.
  // NOTE: sequential state is assigned with <= so that every flop samples
  // pre-edge values; with = the chain would collapse into a single stage.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  // ---------------------------------------------------------------------
  // Interval counter
  // ---------------------------------------------------------------------
  cnt_t  cnt_q, cnt_d;
  ival_t interval;
  logic  timeout;

  // Count cycles since the last edge, saturating at TIMEOUT. The interval
  // is cnt+1 because the edge cycle itself closes the interval. If an edge
  // lands in the timeout cycle, the edge wins and is judged as TIMEOUT+1.
  always_comb begin
    interval = {1'b0, cnt_q} + ival_t'(1);
    timeout  = (cnt_q == TIMEOUT_C) && !edge_q;
    if (edge_q) begin
      cnt_d = '0;
    end else if (cnt_q >= TIMEOUT_C) begin
      cnt_d = TIMEOUT_C;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // Interval counter register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Window classification
  // ---------------------------------------------------------------------
  logic       hit_fast, hit_mid, hit_slow;
  logic       match_hit;
  logic [1:0] match_code;

  // Inclusive +/-TOL windows. Where windows overlap, FAST beats MID and MID
  // beats SLOW. Code 2'b11 cannot come out of this block.
  always_comb begin
    hit_fast   = (interval >= FAST_LO) && (interval <= FAST_HI);
    hit_mid    = (interval >= MID_LO)  && (interval <= MID_HI);
    hit_slow   = (interval >= SLOW_LO) && (interval <= SLOW_HI);
    match_hit  = hit_fast || hit_mid || hit_slow;
    match_code = CODE_MID;
    if (hit_fast) begin
      match_code = CODE_FAST;
    end else if (hit_mid) begin
      match_code = CODE_MID;
    end else if (hit_slow) begin
      match_code = CODE_SLOW;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM and registered outputs
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       err_q, err_d;
  logic       stalled_q, stalled_d;
`ifdef RATE_DEBUG_EN
  cnt_t       last_int_q, last_int_d;
`endif

  // Next-state and next-output logic. Everything only moves on an edge or
  // on a timeout. Strobe and err are single-cycle pulses.
  // NOTE: every signal gets a default at the top of the block, so that no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    code_d    = code_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    stalled_d = stalled_q;
`ifdef RATE_DEBUG_EN
    last_int_d = last_int_q;
`endif

    if (edge_q) begin
      stalled_d = 1'b0;
`ifdef RATE_DEBUG_EN
      // The arming edge has no meaningful interval, so it is not recorded.
      if (state_q != IDLE) begin
        last_int_d = interval[CNT_W-1:0];
      end
`endif
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (match_hit) begin
            state_d = CAND;
            cand_d  = match_code;
          end else begin
            err_d = 1'b1;
          end
        end
        CAND: begin
          if (!match_hit) begin
            state_d = ARMED;
            err_d   = 1'b1;
          end else if (match_code == cand_q) begin
            state_d  = LOCKED;
            code_d   = cand_q;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
          end else begin
            cand_d = match_code;
          end
        end
        LOCKED: begin
          // rate_code keeps its last value when the lock is lost.
          if (!match_hit) begin
            state_d = ARMED;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end else if (match_code != code_q) begin
            state_d = CAND;
            cand_d  = match_code;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (timeout) begin
      state_d   = IDLE;
      stalled_d = 1'b1;
      valid_d   = 1'b0;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cand_q    <= CODE_MID;
      code_q    <= CODE_MID;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
`ifdef RATE_DEBUG_EN
      last_int_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
`ifdef RATE_DEBUG_EN
      last_int_q <= last_int_d;
`endif
    end
  end

  assign rate_code   = code_q;
  assign rate_valid  = valid_q;
  assign rate_strobe = strobe_q;
  assign rate_err    = err_q;
  assign stalled     = stalled_q;
`ifdef RATE_DEBUG_EN
  assign last_interval = last_int_q;
`endif

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb_blink_rate_decoder
//   Drives blink_in as a sequence of half-period gaps. A behavioural model,
//   built from the lock rules, predicts the outputs after each transition.
//   The outputs are compared SYNC_STAGES+2 clocks after each transition.
module tb_blink_rate_decoder;

  localparam int CNT_W       = 8;
  localparam int HALF_FAST   = 25;
  localparam int HALF_MID    = 50;
  localparam int HALF_SLOW   = 90;
  localparam int TOL         = 2;
  localparam int TIMEOUT     = 120;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blink_in = 1'b0;
  logic [1:0] rate_code;
  logic       rate_valid;
  logic       rate_strobe;
  logic       rate_err;
  logic       stalled;
`ifdef RATE_DEBUG_EN
  logic [CNT_W-1:0] last_interval;
`endif

  blink_rate_decoder #(
    .CNT_W       (CNT_W),
    .HALF_MID    (HALF_MID),
    .HALF_SLOW   (HALF_SLOW),
    .HALF_FAST   (HALF_FAST),
    .TOL         (TOL),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .blink_in    (blink_in),
    .rate_code   (rate_code),
    .rate_valid  (rate_valid),
    .rate_strobe (rate_strobe),
    .rate_err    (rate_err),
    .stalled     (stalled)
`ifdef RATE_DEBUG_EN
    ,.last_interval (last_interval)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model
  //   Locked means that the last two judged intervals since arming both
  //   matched the same code. A non-matching interval, a stall or a reset
  //   clears the history. After a stall or reset, one edge is needed to
  //   re-arm the detector.
  // ------------------------------------------------------------------
  bit         m_armed;
  int         m_last;      // code of the previous judged interval, -1 if none
  bit         m_locked;
  logic [1:0] m_code;
  bit         e_strobe;
  bit         e_err;
  int         m_last_int;

  function automatic int classify(input int iv);
    int halves[3];
    int codes[3];
    halves = '{HALF_FAST, HALF_MID, HALF_SLOW};
    codes  = '{2, 0, 1};
    for (int k = 0; k < 3; k++) begin
      if ((iv - halves[k] <= TOL) && (halves[k] - iv <= TOL)) return codes[k];
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_armed    = 0;
    m_last     = -1;
    m_locked   = 0;
    m_code     = 2'b00;
    m_last_int = 0;
  endtask

  task automatic model_edge(input int gap);
    int  c;
    bit  now_locked;
    e_strobe = 0;
    e_err    = 0;
    // Silence longer than TIMEOUT+1 cycles means that a stall happened first.
    if (gap > TIMEOUT + 1) begin
      m_armed  = 0;
      m_last   = -1;
      m_locked = 0;
    end
    if (!m_armed) begin
      m_armed = 1;
      m_last  = -1;
    end else begin
      m_last_int = gap;
      c = classify(gap);
      if (c < 0) begin
        e_err    = 1;
        m_last   = -1;
        m_locked = 0;
      end else begin
        now_locked = (m_last == c);
        e_strobe   = now_locked && !m_locked;
        if (now_locked) m_code = 2'(c);
        m_locked = now_locked;
        m_last   = c;
      end
    end
  endtask

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_code"},    32'(rate_code),   32'd0);
    check({tag, "_valid"},   32'(rate_valid),  32'd0);
    check({tag, "_strobe"},  32'(rate_strobe), 32'd0);
    check({tag, "_err"},     32'(rate_err),    32'd0);
    check({tag, "_stalled"}, 32'(stalled),     32'd0);
  endtask

  // Hold reset for a few clocks, then release it on a falling edge.
  task automatic apply_reset();
    rst      = 1'b1;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
`ifdef RATE_DEBUG_EN
    check("rst_last_int", 32'(last_interval), 32'd0);
`endif
    rst = 1'b0;
    model_reset();
  endtask

  // Toggle blink_in `gap` clocks after the previous toggle (gap >= 6).
  // Outputs are checked LAT clocks later, and the pulses are checked
  // again one clock after that.
  task automatic send(input int gap, input string tag);
    repeat (gap - (LAT + 1)) @(posedge clk);
    #1;
    if (gap >= TIMEOUT + 5 && m_armed) begin
      check({tag, "_pre_stalled"}, 32'(stalled),    32'd1);
      check({tag, "_pre_valid"},   32'(rate_valid), 32'd0);
    end
    blink_in = ~blink_in;
    model_edge(gap);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"},   32'(rate_valid),  32'(m_locked));
    if (m_locked) check({tag, "_code"}, 32'(rate_code), 32'(m_code));
    check({tag, "_strobe"},  32'(rate_strobe), 32'(e_strobe));
    check({tag, "_err"},     32'(rate_err),    32'(e_err));
    check({tag, "_stalled"}, 32'(stalled),     32'd0);
`ifdef RATE_DEBUG_EN
    check({tag, "_last_int"}, 32'(last_interval), 32'(m_last_int));
`endif
    @(negedge clk);
    check({tag, "_strobe_end"}, 32'(rate_strobe), 32'd0);
    check({tag, "_err_end"},    32'(rate_err),    32'd0);
  endtask

  // Guard against the run stalling indefinitely.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int g;
    int halves[3];
    halves = '{HALF_FAST, HALF_MID, HALF_SLOW};

    model_reset();
    apply_reset();

    // Steady 50-cycle halves: lock 00 on the third edge, no further strobes.
    send(10, "mid_arm");
    for (int i = 0; i < 4; i++) send(50, "mid");
    check("mid_lock_code", 32'(rate_code), 32'd0);

    // Switch to 25-cycle halves: unlock first, then relock to 10.
    for (int i = 0; i < 3; i++) send(25, "fast");
    check("fast_lock_code", 32'(rate_code), 32'd2);

    // Silence past TIMEOUT: stall, then the next edge only re-arms.
    send(130, "stall");

    // 52 and 48 lock 00; 53 falls outside every window.
    send(52, "w52");
    send(48, "w48");
    send(53, "w53");

    // Intervals of 70 match nothing and give two error pulses.
    send(70, "w70a");
    send(70, "w70b");
    check("w70_valid", 32'(rate_valid), 32'd0);

    // Lock 01, then an edge exactly in the timeout cycle is judged as 121.
    send(90, "slow_a");
    send(90, "slow_b");
    send(121, "edge_wins");

    // Relock 01, then assert reset asynchronously between clock edges.
    send(90, "slow_c");
    send(90, "slow_d");
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_rst");
    apply_reset();

    // Randomised gaps, mostly near the nominal half-periods.
    send(12, "rnd_arm");
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        g = halves[$urandom_range(0, 2)] + int'($urandom_range(0, 6)) - 3;
      end else begin
        g = int'($urandom_range(6, 130));
      end
      send(g, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
